// File: rtl/linescanner_pkg.sv
// Shared definitions for the line-scanner capture sequencer: FSM state codes,
// default timing constants and the pixel index width.
package linescanner_pkg;

    // Width of the in-line pixel index
    localparam int unsigned PixIdxW = 16;

    // Sequencer states, 3-bit encoding
    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StCvc     = 3'd1;
    localparam logic [2:0] StSkip    = 3'd2;
    localparam logic [2:0] StWaitAdc = 3'd3;
    localparam logic [2:0] StSample  = 3'd4;
    localparam logic [2:0] StHold    = 3'd5;
    localparam logic [2:0] StRecover = 3'd6;

    // Default timing, in pixel_clock cycles
    localparam int unsigned DefDataWidth  = 8;
    localparam int unsigned DefLinePixels = 1024;
    localparam int unsigned DefTCvc       = 50;
    localparam int unsigned DefTSkip      = 8;
    localparam int unsigned DefTSample    = 50;
    localparam int unsigned DefTHold      = 7;
    localparam int unsigned DefTRecover   = 50;
    localparam int unsigned DefLoadDelay  = 4;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/linescanner_load_pulse_gen.sv
// ADC load pulse generator: registers end_adc once, then fires a single-cycle
// load pulse after the registered level has been high LOAD_DELAY cycles.
// At most one pulse per high period; re-arms when the registered level is low.
module linescanner_load_pulse_gen
    import linescanner_pkg::*;
#(
    parameter int unsigned LOAD_DELAY = DefLoadDelay
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic end_adc_i,
    output logic load_pulse_o
);

    localparam int unsigned CntW = max_u($clog2(LOAD_DELAY + 1), 1);

    logic            end_adc_q, end_adc_d;
    logic            arm_q, arm_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            pulse_q, pulse_d;

    // Arm/count/fire decision from the registered end_adc level
    always_comb begin
        end_adc_d = end_adc_i;
        arm_d     = arm_q;
        cnt_d     = cnt_q;
        pulse_d   = 1'b0;
        if (!end_adc_q) begin
            arm_d = 1'b1;
            cnt_d = '0;
        end else if (arm_q) begin
            if (cnt_q == CntW'(LOAD_DELAY)) begin
                pulse_d = 1'b1;
                arm_d   = 1'b0;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State registers, synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            end_adc_q <= 1'b0;
            arm_q     <= 1'b1;
            cnt_q     <= '0;
            pulse_q   <= 1'b0;
        end else begin
            end_adc_q <= end_adc_d;
            arm_q     <= arm_d;
            cnt_q     <= cnt_d;
            pulse_q   <= pulse_d;
        end
    end

    assign load_pulse_o = pulse_q;

endmodule

// File: rtl/linescanner_capture_sequencer.sv
// Line-scanner capture sequencer: drives sensor CVC/CDS resets and the sample
// strobe from parameterised timing, generates the ADC load pulse and registers
// the incoming pixel stream with an in-line index and a line-done pulse.
// Optional: define LINESCANNER_TEST_PATTERN_EN to add the test_mode input,
// which replaces pixel data with the low bits of the pixel index.
module linescanner_capture_sequencer
    import linescanner_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DefDataWidth,
    parameter int unsigned LINE_PIXELS = DefLinePixels,
    parameter int unsigned T_CVC       = DefTCvc,
    parameter int unsigned T_SKIP      = DefTSkip,
    parameter int unsigned T_SAMPLE    = DefTSample,
    parameter int unsigned T_HOLD      = DefTHold,
    parameter int unsigned T_RECOVER   = DefTRecover,
    parameter int unsigned LOAD_DELAY  = DefLoadDelay
) (
    input  logic                  pixel_clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  continuous,
    input  logic                  start,
    input  logic                  end_adc,
    input  logic                  lval,
    input  logic [DATA_WIDTH-1:0] data,
`ifdef LINESCANNER_TEST_PATTERN_EN
    input  logic                  test_mode,
`endif
    output logic                  rst_cvc,
    output logic                  rst_cds,
    output logic                  sample,
    output logic                  load_pulse,
    output logic [DATA_WIDTH-1:0] pixel_data,
    output logic                  pixel_valid,
    output logic [PixIdxW-1:0]    pixel_index,
    output logic                  line_done,
    output logic                  busy
);

    localparam int unsigned TMax =
        max_u(max_u(max_u(T_CVC, T_SKIP), max_u(T_SAMPLE, T_HOLD)), T_RECOVER);
    localparam int unsigned TimerW = $clog2(TMax) + 1;
    localparam logic [PixIdxW-1:0] LastIdx = PixIdxW'(LINE_PIXELS - 1);

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    logic [2:0]        state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [TimerW-1:0] timer_last;
    logic              timer_done;

    // Last timer value of the current timed state; timer is 0 on entry
    always_comb begin
        case (state_q)
            StCvc:     timer_last = TimerW'(T_CVC - 1);
            StSkip:    timer_last = TimerW'(T_SKIP - 1);
            StSample:  timer_last = TimerW'(T_SAMPLE - 1);
            StHold:    timer_last = TimerW'(T_HOLD - 1);
            StRecover: timer_last = TimerW'(T_RECOVER - 1);
            default:   timer_last = '0;
        endcase
    end

    assign timer_done = (timer_q == timer_last);

    // Next state and timer
    always_comb begin
        state_d = state_q;
        timer_d = timer_done ? '0 : timer_q + 1'b1;
        case (state_q)
            StIdle: begin
                timer_d = '0;
                if (enable && (continuous || start)) state_d = StCvc;
            end
            StCvc:     if (timer_done) state_d = StSkip;
            StSkip:    if (timer_done) state_d = StWaitAdc;
            StWaitAdc: begin
                timer_d = '0;
                if (end_adc) state_d = StSample;
            end
            StSample:  if (timer_done) state_d = StHold;
            StHold:    if (timer_done) state_d = StRecover;
            // continuous and enable only matter at the end of recovery
            StRecover: if (timer_done) state_d = (continuous && enable) ? StCvc : StIdle;
            default: begin
                state_d = StIdle;
                timer_d = '0;
            end
        endcase
    end

    // FSM registers, synchronous reset
    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            state_q <= StIdle;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // Sensor strobes decoded from the registered state so they track it exactly
    always_comb begin
        rst_cvc = 1'b1;
        rst_cds = 1'b1;
        sample  = 1'b0;
        busy    = (state_q != StIdle);
        case (state_q)
            StCvc: rst_cvc = 1'b0;
            StSkip, StWaitAdc, StHold: begin
                rst_cvc = 1'b0;
                rst_cds = 1'b0;
            end
            StSample: begin
                rst_cvc = 1'b0;
                rst_cds = 1'b0;
                sample  = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Load pulse
    // ------------------------------------------------------------------
    linescanner_load_pulse_gen #(
        .LOAD_DELAY(LOAD_DELAY)
    ) u_load_pulse_gen (
        .clk_i       (pixel_clock),
        .rst_i       (reset),
        .end_adc_i   (end_adc),
        .load_pulse_o(load_pulse)
    );

    // ------------------------------------------------------------------
    // Pixel path
    // ------------------------------------------------------------------
    logic                  lval_q, lval_d;
    logic                  drop_q, drop_d;      // line full, discard until lval falls
    logic                  valid_q, valid_d;
    logic                  done_q, done_d;
    logic [PixIdxW-1:0]    next_idx_q, next_idx_d;
    logic [PixIdxW-1:0]    idx_q, idx_d;
    logic [DATA_WIDTH-1:0] pix_q, pix_d;
    logic [DATA_WIDTH-1:0] pix_src;
    logic                  accept;

`ifdef LINESCANNER_TEST_PATTERN_EN
    assign pix_src = test_mode ? DATA_WIDTH'(next_idx_q) : data;
`else
    assign pix_src = data;
`endif

    assign accept = lval && !drop_q;

    // Pixel capture, indexing and end-of-line detection
    always_comb begin
        lval_d     = lval;
        valid_d    = accept;
        idx_d      = accept ? next_idx_q : '0;
        pix_d      = pix_q;
        drop_d     = drop_q;
        next_idx_d = next_idx_q;
        // Last-index pixel sets drop, which masks the lval-fall term: one pulse per line
        done_d     = (valid_q && (idx_q == LastIdx)) || (lval_q && !lval && !drop_q);
        if (accept) begin
            pix_d = pix_src;
            if (next_idx_q == LastIdx) begin
                next_idx_d = '0;
                drop_d     = 1'b1;
            end else begin
                next_idx_d = next_idx_q + 1'b1;
            end
        end
        if (!lval) begin
            next_idx_d = '0;
            drop_d     = 1'b0;
        end
    end

    // Pixel path registers, synchronous reset
    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            lval_q     <= 1'b0;
            drop_q     <= 1'b0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            next_idx_q <= '0;
            idx_q      <= '0;
            pix_q      <= '0;
        end else begin
            lval_q     <= lval_d;
            drop_q     <= drop_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            next_idx_q <= next_idx_d;
            idx_q      <= idx_d;
            pix_q      <= pix_d;
        end
    end

    assign pixel_data  = pix_q;
    assign pixel_valid = valid_q;
    assign pixel_index = idx_q;
    assign line_done   = done_q;

endmodule

// File: tb/tb_linescanner_capture_sequencer.sv
// Self-checking bench for linescanner_capture_sequencer: directed scenarios plus
// randomized stimulus, all checked every cycle against a timeline-based model.
module tb_linescanner_capture_sequencer;
    import linescanner_pkg::*;

    localparam int DW = 8;
    localparam int LP = 4;
    localparam int TC = 50, TS = 8, TSA = 50, TH = 7, TR = 50, LD = 4;

    logic pixel_clock = 1'b0;
    always #5 pixel_clock = ~pixel_clock;

    logic          reset = 1'b1, enable = 1'b0, continuous = 1'b0, start = 1'b0;
    logic          end_adc = 1'b0, lval = 1'b0, test_mode = 1'b0;
    logic [DW-1:0] data = '0;

    logic               rst_cvc, rst_cds, sample, load_pulse, pixel_valid, line_done, busy;
    logic [DW-1:0]      pixel_data;
    logic [PixIdxW-1:0] pixel_index;

    linescanner_capture_sequencer #(
        .DATA_WIDTH(DW), .LINE_PIXELS(LP), .T_CVC(TC), .T_SKIP(TS), .T_SAMPLE(TSA),
        .T_HOLD(TH), .T_RECOVER(TR), .LOAD_DELAY(LD)
    ) dut (
        .pixel_clock(pixel_clock), .reset(reset), .enable(enable), .continuous(continuous),
        .start(start), .end_adc(end_adc), .lval(lval), .data(data),
`ifdef LINESCANNER_TEST_PATTERN_EN
        .test_mode(test_mode),
`endif
        .rst_cvc(rst_cvc), .rst_cds(rst_cds), .sample(sample), .load_pulse(load_pulse),
        .pixel_data(pixel_data), .pixel_valid(pixel_valid), .pixel_index(pixel_index),
        .line_done(line_done), .busy(busy)
    );

    int n_cmp = 0, n_err = 0, cyc = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: line timeline (offset into line, sample start offset),
    // registered end_adc run length, pixel count within the lval period.
    int            m_line = -1, m_samp = -1, m_run = 0, m_nin = 0, m_idx = 0;
    bit            m_pulse = 0, m_valid = 0, m_done = 0, m_lval_prev = 0;
    logic [DW-1:0] m_data = '0;

    task automatic model_step();
        bit nd, nv;
        if (reset) begin
            m_line = -1; m_samp = -1; m_run = 0; m_pulse = 0;
            m_nin = 0; m_idx = 0; m_valid = 0; m_done = 0; m_lval_prev = 0; m_data = '0;
            return;
        end
        if (m_line < 0) begin
            if (enable && (continuous || start)) begin m_line = 0; m_samp = -1; end
        end else if (m_samp >= 0 && m_line == m_samp + TSA + TH + TR - 1) begin
            if (continuous && enable) begin m_line = 0; m_samp = -1; end
            else m_line = -1;
        end else begin
            if (m_samp < 0 && m_line >= TC + TS && end_adc) m_samp = m_line + 1;
            m_line++;
        end
        m_pulse = (m_run == LD + 1);
        m_run = end_adc ? ((m_run < 1000) ? m_run + 1 : m_run) : 0;
        nd = (m_valid && m_idx == LP - 1) || (m_lval_prev && !lval && m_nin < LP);
        nv = lval && (m_nin < LP);
        if (nv) m_data = test_mode ? DW'(m_nin) : data;
        m_idx = nv ? m_nin : 0;
        m_valid = nv;
        m_done = nd;
        m_nin = lval ? ((m_nin < LP) ? m_nin + 1 : LP) : 0;
        m_lval_prev = lval;
    endtask

    // Edge bookkeeping on DUT outputs for duration checks
    bit  p_cvc = 1, p_cds = 1, p_samp = 0;
    int  n_lines = 0, n_cds = 0, n_load = 0, n_valid = 0, n_done = 0;
    int  t_cvc_fall = 0, t_s_rise = 0, t_s_fall = 0, t_rst_rise = 0, cvc_len = 0;
    logic [DW-1:0]      q_data[$];
    logic [PixIdxW-1:0] q_idx[$];

    task automatic compare_all();
        int reas;
        bit b;
        reas = (m_samp < 0) ? 32'h3fff_ffff : m_samp + TSA + TH;
        b = (m_line >= 0);
        check_eq("busy", busy, b);
        check_eq("rst_cvc", rst_cvc, !(b && m_line < reas));
        check_eq("rst_cds", rst_cds, !(b && m_line >= TC && m_line < reas));
        check_eq("sample", sample, b && m_samp >= 0 && m_line >= m_samp && m_line < m_samp + TSA);
        check_eq("load_pulse", load_pulse, m_pulse);
        check_eq("pixel_valid", pixel_valid, m_valid);
        check_eq("pixel_index", pixel_index, m_idx);
        check_eq("pixel_data", pixel_data, m_data);
        check_eq("line_done", line_done, m_done);
    endtask

    task automatic monitor();
        if (p_cvc && !rst_cvc) begin n_lines++; t_cvc_fall = cyc; end
        if (p_cds && !rst_cds) begin n_cds++; cvc_len = cyc - t_cvc_fall; end
        if (!p_samp && sample) t_s_rise = cyc;
        if (p_samp && !sample) t_s_fall = cyc;
        if (!p_cvc && rst_cvc) t_rst_rise = cyc;
        if (load_pulse) n_load++;
        if (line_done) n_done++;
        if (pixel_valid) begin
            n_valid++;
            q_data.push_back(pixel_data);
            q_idx.push_back(pixel_index);
        end
        p_cvc = rst_cvc; p_cds = rst_cds; p_samp = sample;
    endtask

    task automatic tick();
        model_step();
        @(posedge pixel_clock);
        @(negedge pixel_clock);
        cyc++;
        compare_all();
        monitor();
    endtask

    task automatic wait_idle(input int max_cyc, input string tag);
        int k = 0;
        while (busy && k < max_cyc) begin tick(); k++; end
        check_eq(tag, busy, 0);
    endtask

    task automatic wait_cds(input int max_cyc, input string tag);
        int k = 0;
        int c0 = n_cds;
        while (n_cds == c0 && k < max_cyc) begin tick(); k++; end
        check_eq(tag, n_cds - c0, 1);
    endtask

    task automatic wait_cvc(input int max_cyc, input string tag);
        int k = 0;
        int c0 = n_lines;
        while (n_lines == c0 && k < max_cyc) begin tick(); k++; end
        check_eq(tag, n_lines - c0, 1);
    endtask

    initial begin
        int l0, v0, d0, k;

        // Reset values (checked by the per-cycle compare)
        reset = 1'b1;
        repeat (3) tick();
        check_eq("reset_rst_cvc", rst_cvc, 1);
        check_eq("reset_busy", busy, 0);

        // Continuous line with default timing
        reset = 1'b0; enable = 1'b1; continuous = 1'b1;
        wait_cds(200, "first_cds_fall");
        repeat (19) tick();
        l0 = n_load;
        end_adc = 1'b1;
        repeat (10) tick();
        end_adc = 1'b0;
        repeat (3) tick();
        check_eq("load_once_10cyc", n_load - l0, 1);
        wait_cvc(400, "second_cvc_fall");
        check_eq("cvc_low_len", cvc_len, TC);
        check_eq("sample_len", t_s_fall - t_s_rise, TSA);
        check_eq("hold_len", t_rst_rise - t_s_fall, TH);
        check_eq("recover_len", t_cvc_fall - t_rst_rise, TR);
        // Short end_adc pulse during CVC: no load pulse
        l0 = n_load;
        end_adc = 1'b1;
        repeat (3) tick();
        end_adc = 1'b0;
        repeat (8) tick();
        check_eq("load_none_3cyc", n_load - l0, 0);

        // Single-shot mode
        continuous = 1'b0;
        end_adc = 1'b1;
        wait_idle(400, "cont_line_ends");
        end_adc = 1'b0;
        repeat (3) tick();
        l0 = n_lines;
        start = 1'b1; tick(); start = 1'b0;
        repeat (20) tick();
        start = 1'b1; tick(); start = 1'b0;
        end_adc = 1'b1;
        wait_idle(400, "single_line_ends");
        end_adc = 1'b0;
        repeat (5) tick();
        check_eq("single_shot_lines", n_lines - l0, 1);
        check_eq("single_shot_idle", busy, 0);

        // Pixel path: 6 pixels offered on a 4-pixel line
        q_data.delete(); q_idx.delete();
        v0 = n_valid; d0 = n_done;
        for (int i = 1; i <= 6; i++) begin lval = 1'b1; data = DW'(i); tick(); end
        lval = 1'b0;
        repeat (4) tick();
        check_eq("pix_valid_count", n_valid - v0, LP);
        check_eq("pix_done_count", n_done - d0, 1);
        check_eq("pix_index_rest", pixel_index, 0);
        for (int i = 0; i < q_data.size() && i < LP; i++) begin
            check_eq("pix_seq_data", q_data[i], i + 1);
            check_eq("pix_seq_idx", q_idx[i], i);
        end

        // Reset in the middle of SAMPLE
        continuous = 1'b1; end_adc = 1'b1;
        k = 0;
        while (!sample && k < 400) begin tick(); k++; end
        check_eq("sample_reached", sample, 1);
        repeat (10) tick();
        reset = 1'b1; tick();
        check_eq("rst_mid_sample", sample, 0);
        check_eq("rst_mid_cvc", rst_cvc, 1);
        check_eq("rst_mid_cds", rst_cds, 1);
        check_eq("rst_mid_busy", busy, 0);
        reset = 1'b0; end_adc = 1'b0;
        wait_cds(200, "restart_cds_fall");
        check_eq("restart_cvc_len", cvc_len, TC);

`ifdef LINESCANNER_TEST_PATTERN_EN
        // Test pattern replaces data with the pixel index
        q_data.delete(); q_idx.delete();
        test_mode = 1'b1;
        for (int i = 0; i < LP; i++) begin lval = 1'b1; data = DW'($urandom); tick(); end
        lval = 1'b0;
        repeat (3) tick();
        test_mode = 1'b0;
        check_eq("tp_count", q_data.size(), LP);
        for (int i = 0; i < q_data.size() && i < LP; i++) check_eq("tp_data", q_data[i], i);
`endif

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            reset      = ($urandom_range(0, 499) == 0);
            enable     = ($urandom_range(0, 15) != 0);
            continuous = ($urandom_range(0, 3) != 0);
            start      = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 5) == 0) end_adc = ~end_adc;
            if ($urandom_range(0, 4) == 0) lval = ~lval;
            data = DW'($urandom);
`ifdef LINESCANNER_TEST_PATTERN_EN
            test_mode = ($urandom_range(0, 3) == 0);
`endif
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/linescanner_capture_sequencer.md
Name: linescanner_capture_sequencer

Overview:
- Parametrised successor to the line-scanner capture unit. Drives the sensor reset, CDS and sample strobes and the ADC load pulse.
- Timing comes from parameters, not hard-coded counts.
- Adds single-shot/continuous mode, a registered pixel stream with in-line pixel index and line-done pulse, and a fully synchronous load-pulse generator with no asynchronous edge logic.
- Sits between the sensor/ADC pins and the line buffer / DMA front end.

Parameters:
- DATA_WIDTH, 8, ADC pixel width.
- LINE_PIXELS, 1024, pixels per line; range 2..65535.
- T_CVC, 50, cycles rst_cvc is held low before rst_cds is released.
- T_SKIP, 8, cycles after rst_cds release before end_adc is honoured.
- T_SAMPLE, 50, cycles sample is held high.
- T_HOLD, 7, cycles between sample falling and reset re-assertion.
- T_RECOVER, 50, cycles with both resets asserted before the next line.
- LOAD_DELAY, 4, cycles end_adc must stay high before load_pulse fires.

Ports:
- pixel_clock, in, 1, sole clock; all logic on its rising edge.
- reset, in, 1, synchronous, active-high reset.
- enable, in, 1, sequencer run enable.
- continuous, in, 1: 1 = free-running lines; 0 = one line per start.
- start, in, 1, single-cycle pulse; starts one line when continuous=0.
- end_adc, in, 1, ADC conversion-end level from the sensor.
- lval, in, 1, line-valid from the sensor.
- data, in, DATA_WIDTH, ADC pixel data.
- rst_cvc, out, 1, sensor CVC reset, active-high.
- rst_cds, out, 1, sensor CDS reset, active-high.
- sample, out, 1, sample strobe.
- load_pulse, out, 1, one-cycle ADC load pulse.
- pixel_data, out, DATA_WIDTH, registered pixel.
- pixel_valid, out, 1, pixel_data is valid this cycle.
- pixel_index, out, 16, index of the current pixel in the line.
- line_done, out, 1, one-cycle pulse after the last pixel of a line.
- busy, out, 1, high when the state machine is not in IDLE.

Behaviour:
- Reset values:
  - rst_cvc=1, rst_cds=1.
  - sample, load_pulse, pixel_valid, line_done, busy = 0.
  - pixel_data=0, pixel_index=0.
  - State = IDLE, all counters = 0, load arm = 1.
- Timing counter width is $clog2 of the largest T_* parameter + 1. Each timed state lasts exactly its T_* cycles, measured from the cycle of entry.
- IDLE:
  - Resets asserted.
  - Go to CVC when enable=1 and either continuous=1 or start=1.
  - start is ignored when the state is not IDLE.
- CVC: rst_cvc=0 from the entry cycle. After T_CVC cycles, set rst_cds=0 and go to SKIP.
- SKIP: count T_SKIP cycles, then go to WAIT_ADC.
- WAIT_ADC: wait indefinitely for end_adc=1. On that cycle set sample=1 and go to SAMPLE.
- SAMPLE: sample=1 for T_SAMPLE cycles, then sample=0 and go to HOLD.
- HOLD: after T_HOLD cycles set rst_cvc=rst_cds=1 and go to RECOVER.
- RECOVER:
  - After T_RECOVER cycles, go to CVC if continuous=1 and enable=1; otherwise go to IDLE.
  - continuous is sampled at this point only.
- enable=0 mid-line: the current line completes; the next transition out of RECOVER goes to IDLE. Strobes are never truncated.
- reset mid-operation: everything returns to reset values on the next edge. Any pulse in progress is dropped.
- Load pulse:
  - end_adc is registered once; the arm bit re-arms on any cycle where the registered end_adc=0.
  - While armed and end_adc is high, a counter increments each cycle. When it reaches LOAD_DELAY, load_pulse=1 for exactly one cycle, then disarm and clear the counter.
  - If end_adc drops before the count is reached, the counter clears. At most one pulse per end_adc high period.
- Pixel path:
  - pixel_data and pixel_valid are registered from data and lval; latency is 1 cycle.
  - pixel_index increments after each valid pixel.
  - On the valid pixel with index LINE_PIXELS-1, or on lval falling (whichever comes first), line_done pulses in the following cycle and pixel_index returns to 0.
  - Pixels beyond LINE_PIXELS within the same lval are dropped (pixel_valid=0) until lval falls.

Optional Feature:
- Macro: LINESCANNER_TEST_PATTERN_EN.
- Defined: adds input test_mode (1 bit). When test_mode=1, pixel_data = pixel_index[DATA_WIDTH-1:0] instead of data; valid and index behaviour is unchanged.
- Undefined: no test_mode port; pixel_data is always taken from data.

Decomposition:
- Shared package linescanner_pkg holds:
  - the state enumeration (IDLE, CVC, SKIP, WAIT_ADC, SAMPLE, HOLD, RECOVER), 3-bit encoding;
  - the default timing constants;
  - the pixel index width of 16.
- One natural sub-module, linescanner_load_pulse_gen, containing the end_adc register, arm bit, delay counter and load_pulse output.

Test Plan:
- Defaults, continuous=1, enable=1, end_adc rises 20 cycles after rst_cds falls:
  - rst_cvc low 50 cycles before rst_cds falls;
  - sample high exactly 50 cycles;
  - resets re-asserted 7 cycles after sample falls;
  - next rst_cvc fall 50 cycles later.
- continuous=0, single start pulse: one full line, busy drops in IDLE, a second start during busy is ignored.
- end_adc held high for 10 cycles: exactly one load_pulse, 5 cycles after the registered rise. A 3-cycle end_adc high period produces no pulse.
- LINE_PIXELS=4, lval high for 6 cycles with data 1..6:
  - pixel_valid is high for 4 cycles, with indices 0..3 and data 1..4;
  - one line_done pulse;
  - index returns to 0.
- reset asserted mid-SAMPLE: next cycle sample=0, rst_cvc=rst_cds=1, busy=0. Restart gives a full-length CVC phase.
- With LINESCANNER_TEST_PATTERN_EN and test_mode=1: pixel_data follows 0,1,2,3 regardless of data.
